// File: rtl/vga_sync_recover.sv
// rtl/vga_sync_recover.sv - VGA hsync/vsync receiver: timing checks, lock FSM, hpos/vpos/display_en regeneration
module vga_sync_recover #(
  parameter int HVisible   = 640,
  parameter int HSyncBegin = 656,
  parameter int HSyncWidth = 96,
  parameter int HTotal     = 799,
  parameter int VVisible   = 480,
  parameter int VSyncBegin = 490,
  parameter int VTotal     = 524,
  parameter int LockFrames = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       locked,
  output logic       display_en,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam int GW = (LockFrames > 2) ? $clog2(LockFrames) : 1;

  localparam logic [9:0]    H_VIS     = 10'(HVisible);
  localparam logic [9:0]    H_SB      = 10'(HSyncBegin);
  localparam logic [9:0]    H_TOT     = 10'(HTotal);
  localparam logic [9:0]    V_VIS     = 10'(VVisible);
  localparam logic [9:0]    V_SB      = 10'(VSyncBegin);
  localparam logic [9:0]    V_TOT     = 10'(VTotal);
  localparam logic [10:0]   L_PERIOD  = 11'(HTotal + 1);
  localparam logic [10:0]   L_TIMEOUT = 11'(2 * (HTotal + 1));
  localparam logic [9:0]    F_LINES   = 10'(VTotal + 1);
  localparam logic [8:0]    H_WIDTH   = 9'(HSyncWidth);
  localparam logic [GW-1:0] G_LAST    = GW'(LockFrames - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] gcnt;
  logic          hs_q;
  logic          vs_q;
  logic [10:0]   lcnt;
  logic [7:0]    wcnt;
  logic [9:0]    fcnt;
  logic          hs_armed;
  logic          to_fired;

  logic          hs_rise;
  logic          hs_fall;
  logic          vs_rise;
  logic          timeout_hit;
  logic          err_line;
  logic          err_width;
  logic          err_frame;
  logic          err_any;
  logic [1:0]    err_new;
  logic [9:0]    hpos_n;
  logic [9:0]    vpos_n;
  logic          lock_n;

  always_comb begin
    hs_rise = hsync_in & ~hs_q;
    hs_fall = ~hsync_in & hs_q;
    vs_rise = vsync_in & ~vs_q;
  end

  // The first hsync after (re)entering SEARCH has no valid reference, so its period is not judged.
  always_comb begin
    timeout_hit = (lcnt == L_TIMEOUT) && !to_fired && !hs_rise;
    err_line    = hs_rise && hs_armed && (lcnt != L_PERIOD);
    err_width   = hs_fall && (({1'b0, wcnt} + 9'd1) != H_WIDTH);
    err_frame   = (vs_rise && (state != ST_SEARCH) && (fcnt != F_LINES)) || timeout_hit;
    err_any     = err_line | err_width | err_frame;
    err_new     = 2'd0;
    if (err_frame)      err_new = 2'd3;
    else if (err_width) err_new = 2'd2;
    else if (err_line)  err_new = 2'd1;
  end

  // A vsync load takes precedence over the end-of-line vpos step.
  always_comb begin
    hpos_n = hpos;
    vpos_n = vpos;
    if (hs_rise)             hpos_n = H_SB;
    else if (hpos == H_TOT)  hpos_n = 10'd0;
    else                     hpos_n = hpos + 10'd1;
    if (vs_rise)             vpos_n = V_SB;
    else if (hpos == H_TOT)  vpos_n = (vpos == V_TOT) ? 10'd0 : vpos + 10'd1;
  end

  always_comb begin
    lock_n = 1'b0;
    case (state)
      ST_LOCKED: lock_n = !err_any;
      ST_VERIFY: lock_n = vs_rise && !err_any && (gcnt == G_LAST);
      default:   lock_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hpos       <= 10'd0;
      vpos       <= 10'd0;
      lcnt       <= 11'd0;
      wcnt       <= 8'd0;
      fcnt       <= 10'd0;
      to_fired   <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= 2'd0;
      display_en <= 1'b0;
    end else begin
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      hpos <= hpos_n;
      vpos <= vpos_n;

      if (hs_rise)                lcnt <= 11'd1;
      else if (lcnt != 11'h7FF)   lcnt <= lcnt + 11'd1;

      if (!hs_q)                  wcnt <= 8'd0;
      else if (wcnt != 8'hFF)     wcnt <= wcnt + 8'd1;

      if (vs_rise)                fcnt <= hs_rise ? 10'd1 : 10'd0;
      else if (hs_rise && fcnt != 10'h3FF) fcnt <= fcnt + 10'd1;

      // Timeout reports once per stall; any hsync activity re-arms it.
      if (hs_rise || hs_fall)     to_fired <= 1'b0;
      else if (timeout_hit)       to_fired <= 1'b1;

      err_pulse <= err_any;
      if (err_any) err_code <= err_new;

      display_en <= lock_n && (hpos_n < H_VIS) && (vpos_n < V_VIS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_SEARCH;
      gcnt     <= '0;
      locked   <= 1'b0;
      hs_armed <= 1'b0;
    end else begin
      locked <= lock_n;
      if (hs_rise) hs_armed <= 1'b1;
      if (err_any) begin
        state    <= ST_SEARCH;
        gcnt     <= '0;
        hs_armed <= 1'b0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (vs_rise) begin
              state <= ST_VERIFY;
              gcnt  <= '0;
            end
          end
          ST_VERIFY: begin
            if (vs_rise) begin
              if (lock_n) state <= ST_LOCKED;
              else        gcnt  <= gcnt + GW'(1);
            end
          end
          ST_LOCKED: state <= ST_LOCKED;
          default:   state <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_recover.sv
// tb/tb_vga_sync_recover.sv - directed bench for vga_sync_recover on a scaled-down timing
module tb_vga_sync_recover;

  localparam int HV  = 16;
  localparam int HSB = 20;
  localparam int HSW = 6;
  localparam int HT  = 31;
  localparam int VV  = 12;
  localparam int VSB = 14;
  localparam int VT  = 19;
  localparam int LF  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       locked;
  logic       display_en;
  logic       err_pulse;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  int gh, gv, hlast, vlast, pw;
  bit gen_on = 1'b0;
  bit prev_h = 1'b0;
  bit prev_v = 1'b0;
  int iter = 0;
  int vs_rises = 0;
  int last_vs_iter = 0;
  int last_hs_iter = 0;
  int last_err_iter = 0;
  int err_total = 0;
  int hpos_bad = 0;
  int disp_cnt = 0;
  int n0, e0;

  always #5 clk = ~clk;

  vga_sync_recover #(
    .HVisible(HV), .HSyncBegin(HSB), .HSyncWidth(HSW), .HTotal(HT),
    .VVisible(VV), .VSyncBegin(VSB), .VTotal(VT), .LockFrames(LF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .hpos(hpos),
    .vpos(vpos),
    .locked(locked),
    .display_en(display_en),
    .err_pulse(err_pulse),
    .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic restart_gen();
    gh = 0; gv = 0; hlast = HT; vlast = VT; pw = HSW; gen_on = 1'b1;
  endtask

  // One pixel clock: drive syncs from the generator, sample #1 after the edge, advance.
  task automatic cycle();
    hsync_in = gen_on && (gh >= HSB) && (gh < HSB + pw);
    vsync_in = gen_on && (gv >= VSB) && (gv < VSB + 2);
    @(posedge clk);
    #1;
    iter++;
    if (hsync_in && !prev_h) begin
      last_hs_iter = iter;
      if (hpos != 10'(HSB)) hpos_bad++;
    end
    if (vsync_in && !prev_v) begin
      vs_rises++;
      last_vs_iter = iter;
    end
    if (err_pulse) begin
      err_total++;
      last_err_iter = iter;
    end
    if (display_en) disp_cnt++;
    prev_h = hsync_in;
    prev_v = vsync_in;
    if (gen_on) begin
      gh++;
      if (gh > hlast) begin
        gh = 0; hlast = HT; pw = HSW; gv++;
        if (gv > vlast) begin
          gv = 0; vlast = VT;
        end
      end
    end
  endtask

  task automatic run_until_vs(input int target);
    for (int n = 0; n < 5000 && vs_rises < target; n++) cycle();
    check("vs_wait", vs_rises, target);
  endtask

  task automatic run_until_err(input string tag, input int bound);
    int e;
    e = err_total;
    for (int n = 0; n < bound && err_total == e; n++) cycle();
    check(tag, err_total, e + 1);
  endtask

  task automatic run_until_pos(input int h, input int v);
    for (int n = 0; n < 2000 && !(gh == h && gv == v); n++) cycle();
  endtask

  initial begin
    #12;
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_locked", locked, 0);
    check("rst_display_en", display_en, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    restart_gen();

    // nominal lock-up
    run_until_vs(2);
    check("nom_locked_before_3rd_vs", locked, 0);
    run_until_vs(3);
    check("nom_locked_at_3rd_vs", locked, 1);
    check("nom_vpos_vsync_load", vpos, VSB);
    check("nom_hpos_at_vsync", hpos, 0);
    disp_cnt = 0;
    repeat (HT + 1) cycle();
    check("nom_vpos_next_line", vpos, VSB + 1);
    run_until_vs(4);
    check("nom_display_count", disp_cnt, HV * VV);
    check("nom_no_errors", err_total, 0);
    check("nom_hpos_after_hsync", hpos_bad, 0);

    // one line one clock too long
    run_until_pos(0, 3);
    hlast = HT + 1;
    e0 = err_total;
    run_until_err("long_err_wait", 200);
    check("long_err_code", err_code, 1);
    check("long_locked_drop", locked, 0);
    check("long_err_at_hsync", last_err_iter, last_hs_iter);
    cycle();
    check("long_err_one_cycle", err_pulse, 0);
    n0 = vs_rises;
    run_until_vs(n0 + 2);
    check("long_not_relocked", locked, 0);
    run_until_vs(n0 + 3);
    check("long_relocked", locked, 1);
    check("long_single_err", err_total, e0 + 1);

    // hsync pulse one clock short
    run_until_pos(0, 5);
    pw = HSW - 1;
    run_until_err("width_err_wait", 200);
    check("width_err_code", err_code, 2);
    check("width_locked_drop", locked, 0);
    check("width_err_at_fall", last_err_iter - last_hs_iter, HSW - 1);

    // frame one line short
    n0 = vs_rises;
    run_until_vs(n0 + 1);
    run_until_pos(0, 0);
    vlast = VT - 1;
    run_until_err("frame_err_wait", 2000);
    check("frame_err_code", err_code, 3);
    check("frame_err_at_vsync", last_err_iter, last_vs_iter);

    // syncs stop: timeout fires once
    run_until_pos(0, 2);
    gen_on = 1'b0;
    e0 = err_total;
    repeat (8 * (HT + 1)) cycle();
    check("timeout_single_pulse", err_total, e0 + 1);
    check("timeout_err_code", err_code, 3);
    check("timeout_latency", last_err_iter - last_hs_iter, 2 * (HT + 1));

    // resume, relock, then async reset mid-frame
    restart_gen();
    n0 = vs_rises;
    run_until_vs(n0 + 3);
    check("resume_relocked", locked, 1);
    check("resume_err_code_held", err_code, 3);
    run_until_pos(5, 3);
    cycle();
    check("mid_hpos", hpos, 5);
    check("mid_display_en", display_en, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_hpos", hpos, 0);
    check("arst_vpos", vpos, 0);
    check("arst_locked", locked, 0);
    check("arst_display_en", display_en, 0);
    check("arst_err_code", err_code, 0);
    check("arst_err_pulse", err_pulse, 0);
    #3;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    prev_h = 1'b0;
    prev_v = 1'b0;
    reset = 1'b0;
    restart_gen();
    n0 = vs_rises;
    run_until_vs(n0 + 2);
    check("post_rst_not_locked", locked, 0);
    run_until_vs(n0 + 3);
    check("post_rst_locked", locked, 1);
    check("final_hpos_after_hsync", hpos_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_recover.md
Name: vga_sync_recover

Overview:
- Receive side of the 640x480@60 VGA timing interface: consumes active-high hsync/vsync from the sync generator (or a captured stream) on the pixel clock.
- Measures line period, hsync width and lines per frame, and runs a lock state machine.
- Regenerates hpos/vpos plus a display-enable for downstream consumers, such as the Life renderer in loopback test, or frame checkers.

Parameters:
HVisible, 640, visible pixels per line
HSyncBegin, 656, hpos value loaded on hsync rising edge
HSyncWidth, 96, required hsync high width in clocks
HTotal, 799, last hpos of a line (period = HTotal+1 = 800)
VVisible, 480, visible lines per frame
VSyncBegin, 490, vpos value loaded on vsync rising edge
VTotal, 524, last vpos of a frame (frame = VTotal+1 = 525 lines)
LockFrames, 2, consecutive error-free frames required to assert locked

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
hsync_in  input  1  horizontal sync, active-high
vsync_in  input  1  vertical sync, active-high
hpos  output  10  recovered horizontal position
vpos  output  10  recovered vertical position
locked  output  1  timing verified and stable
display_en  output  1  locked && hpos < HVisible && vpos < VVisible
err_pulse  output  1  one-cycle pulse on any timing error
err_code  output  2  last error: 0 none, 1 line period, 2 hsync width, 3 frame length/timeout

Behaviour:
- Reset (async, active-high) clears all outputs and internal state:
  - hpos = vpos = 0; locked = display_en = err_pulse = 0; err_code = 0.
  - FSM = SEARCH; hs_q = vs_q = 0.
- Edge detection:
  - hs_q/vs_q register the inputs each clk.
  - Rising edge = in && !q; falling edge = !in && q.
  - No input synchronizers: inputs are same-clock domain.
- hpos:
  - On the hsync rising edge the next hpos = HSyncBegin.
  - Otherwise hpos = 0 if hpos == HTotal, else hpos+1.
- vpos:
  - On the vsync rising edge the next vpos = VSyncBegin.
  - Otherwise, when hpos == HTotal: vpos = 0 if vpos == VTotal, else vpos+1.
  - If both the vsync load and an hpos wrap occur in the same cycle, the vsync load wins.
- Line period counter lcnt (11 bits):
  - Reset to 1 on an hsync rising edge, else incremented, saturating at 2047.
  - At each hsync rising edge (except the first after entering SEARCH), lcnt != HTotal+1 gives error 1.
- Hsync width counter wcnt:
  - Counts cycles with hs_q high.
  - At an hsync falling edge, wcnt != HSyncWidth gives error 2.
- Line counter fcnt (10 bits):
  - Incremented on each hsync rising edge; cleared on a vsync rising edge.
  - At a vsync rising edge (except the first after SEARCH), fcnt != VTotal+1 gives error 3.
- Timeout: lcnt reaching 2*(HTotal+1) with no hsync edge gives error 3; fires once, then is held until the next hsync edge.
- Error handling:
  - Any error: err_pulse high exactly one cycle (registered, one cycle after the detecting edge) and err_code updated.
  - err_code holds until the next error or reset.
  - If errors coincide, the highest code wins.
- FSM:
  - SEARCH: locked = 0; the first vsync rising edge goes to VERIFY, with the good-frame counter gcnt = 0.
  - VERIFY: each vsync rising edge with no error in the elapsed frame increments gcnt. When gcnt reaches LockFrames, go to LOCKED. Any error goes to SEARCH.
  - LOCKED: locked = 1. Any error goes to SEARCH, with locked cleared on the same cycle err_pulse asserts.
- Errors are evaluated in every state; err_pulse can fire in SEARCH.
- display_en is registered from the same-cycle hpos/vpos next values, so it aligns with hpos/vpos.
- All counters wrap or saturate explicitly; there is no X propagation after reset.

Test Plan:
- Nominal 800x525 stream from the sync generator after reset:
  - err_pulse never asserts.
  - locked rises at the 3rd vsync rising edge after reset release (first edge enters VERIFY, then 2 good frames).
  - hpos == 656 the cycle after each hsync rising edge.
- Locked stream, inspect vpos and display_en:
  - vpos == 490 after the vsync edge, then 491, etc.
  - display_en high for exactly 640x480 = 307200 cycles per frame.
- Lengthen one line to 801 clocks while locked:
  - err_pulse for 1 cycle; err_code = 1; locked drops.
  - Relock after 3 further clean vsync edges.
- Hsync pulse of 95 clocks with correct period:
  - err_code = 2; FSM returns to SEARCH.
- Frame of 524 lines: err_code = 3 at the vsync edge.
- Hold hsync_in low:
  - err_code = 3 once lcnt reaches 1600; a single err_pulse only.
- Assert reset mid-frame while locked:
  - All outputs return to 0 immediately (asynchronously), without waiting for a clk edge.
  - Relock requires the full SEARCH→VERIFY sequence again.
